// File: rtl/fifo_rd_stream_adapter.sv
// Read-side stream adapter for the async FIFO: credit-limited prefetch into a skid buffer.
// Optional transfer counter enabled by defining FIFO_RD_STREAM_ADAPTER_XFER_CNT_EN.
module fifo_rd_stream_adapter #(
  parameter int BITWIDTH  = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       FIFO_EMPTY,
  output logic                       FIFO_R_EN,
  input  logic [BITWIDTH-1:0]        FIFO_DATA,
  input  logic                       FIFO_DATA_VALID,
  output logic [BITWIDTH-1:0]        M_DATA,
  output logic                       M_VALID,
  input  logic                       M_READY,
  output logic [$clog2(BUF_DEPTH):0] OCCUPANCY,
  output logic                       ERR_STRAY
`ifdef FIFO_RD_STREAM_ADAPTER_XFER_CNT_EN
  ,
  output logic [31:0]                XFER_CNT
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [BITWIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic                inflight_q, inflight_d;
  logic                err_q, err_d;
  logic                pop, push;
  logic [OCC_W:0]      committed;

  assign M_VALID   = (occ_q != '0);
  assign M_DATA    = mem_q[rd_ptr_q];
  assign OCCUPANCY = occ_q;
  assign ERR_STRAY = err_q;

  // Credit counts words already buffered plus the one in flight, minus the word
  // leaving this cycle; that M_READY term is what lets depth 2 run at full rate.
  always_comb begin
    pop        = M_VALID && M_READY;
    push       = FIFO_DATA_VALID && inflight_q;
    committed  = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q} - {{OCC_W{1'b0}}, pop};
    FIFO_R_EN  = !RST && !FIFO_EMPTY && (committed < (OCC_W+1)'(BUF_DEPTH));
    inflight_d = FIFO_R_EN;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    occ_d      = occ_q + OCC_W'(push) - OCC_W'(pop);
    err_d      = err_q || (FIFO_DATA_VALID && !inflight_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      if (push) mem_q[wr_ptr_q] <= FIFO_DATA;
    end
  end

`ifdef FIFO_RD_STREAM_ADAPTER_XFER_CNT_EN
  logic [31:0] xfer_cnt_q, xfer_cnt_d;

  assign xfer_cnt_d = xfer_cnt_q + 32'(pop);
  assign XFER_CNT   = xfer_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) xfer_cnt_q <= '0;
    else     xfer_cnt_q <= xfer_cnt_d;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Scoreboard bench for fifo_rd_stream_adapter with a 1-cycle-latency FIFO read model.
// Exercises the transfer counter when FIFO_RD_STREAM_ADAPTER_XFER_CNT_EN is defined.
module tb_fifo_rd_stream_adapter;
  localparam int W = 32;
  localparam int D = 2;

  logic          clk, rst;
  logic          fifo_empty, fifo_r_en, fifo_dv;
  logic [W-1:0]  fifo_data, m_data;
  logic          m_valid, m_ready, err_stray;
  logic [$clog2(D):0] occupancy;
`ifdef FIFO_RD_STREAM_ADAPTER_XFER_CNT_EN
  logic [31:0]   xfer_cnt;
`endif

  fifo_rd_stream_adapter #(.BITWIDTH(W), .BUF_DEPTH(D)) dut (
    .CLK(clk), .RST(rst),
    .FIFO_EMPTY(fifo_empty), .FIFO_R_EN(fifo_r_en),
    .FIFO_DATA(fifo_data), .FIFO_DATA_VALID(fifo_dv),
    .M_DATA(m_data), .M_VALID(m_valid), .M_READY(m_ready),
    .OCCUPANCY(occupancy), .ERR_STRAY(err_stray)
`ifdef FIFO_RD_STREAM_ADAPTER_XFER_CNT_EN
    , .XFER_CNT(xfer_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, n_ren = 0, n_pop = 0;
  int first_ren = -1, last_ren = -1, first_pop = -1, last_pop = -1;
  int first_dv = -1, first_mv = -1;
  logic iss_s = 1'b0, inject_stray = 1'b0;
  logic prev_mv = 1'b0, prev_rdy = 1'b0, prev_rst = 1'b1;
  logic [W-1:0] prev_data = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_stats();
    n_ren = 0; n_pop = 0;
    first_ren = -1; last_ren = -1; first_pop = -1; last_pop = -1;
    first_dv = -1; first_mv = -1;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      step();
      if (exp_q.size() == 0 && !m_valid) break;
    end
    check_eq("drain_left", exp_q.size(), 0);
  endtask

  // FIFO read side: a request seen in cycle t returns data during cycle t+1.
  always @(posedge clk) begin
    #1;
    if (iss_s && fifo_q.size() > 0) begin
      fifo_dv   = 1'b1;
      fifo_data = fifo_q.pop_front();
    end else begin
      fifo_dv   = inject_stray;
      fifo_data = 32'h5757_0000;
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  always @(negedge clk) begin
    cyc++;
    iss_s = fifo_r_en && !fifo_empty;
    if (!rst) begin
      if (iss_s) begin
        n_ren++;
        if (first_ren < 0) first_ren = cyc;
        last_ren = cyc;
      end
      if (fifo_dv && first_dv < 0) first_dv = cyc;
      if (m_valid && first_mv < 0) first_mv = cyc;
      if (prev_mv && !prev_rdy && !prev_rst) begin
        check_eq("hold_data", m_data, prev_data);
        check_eq("hold_valid", m_valid, 1);
      end
      if (m_valid && m_ready) begin
        n_pop++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (exp_q.size() == 0) check_eq("pop_no_expect", m_valid && m_ready, 0);
        else check_eq("data", m_data, exp_q.pop_front());
      end
    end
    prev_mv = m_valid; prev_rdy = m_ready; prev_data = m_data; prev_rst = rst;
  end

  initial begin
    rst = 1'b1; m_ready = 1'b1; fifo_empty = 1'b1; fifo_dv = 1'b0; fifo_data = '0;
    repeat (2) step();

    // Drain: words queued while in reset, then released
    for (int i = 0; i < 8; i++) push_word(32'h10 + i);
    step();
    check_eq("rst_ren_gated", fifo_r_en, 0);
    step();
    rst = 1'b0;
    clear_stats();
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_data", m_data, 0);
    check_eq("rst_occ", occupancy, 0);
    check_eq("rst_err", err_stray, 0);
    wait_drain(40);
    check_eq("drain_pops", n_pop, 8);
    check_eq("drain_pop_span", last_pop - first_pop, 7);
    check_eq("drain_ren", n_ren, 8);
    check_eq("drain_ren_span", last_ren - first_ren, 7);
    check_eq("drain_latency", first_pop - first_ren, 2);

    // Backpressure
    m_ready = 1'b0;
    step();
    clear_stats();
    for (int i = 0; i < 5; i++) push_word(32'h20 + i);
    repeat (8) step();
    check_eq("bp_reads", n_ren, 2);
    check_eq("bp_occ", occupancy, 2);
    check_eq("bp_head", m_data, 32'h20);
    check_eq("bp_valid", m_valid, 1);
    m_ready = 1'b1;
    wait_drain(40);
    check_eq("bp_pops", n_pop, 5);

    // Empty edge
    step();
    clear_stats();
    push_word(32'hAB);
    repeat (6) step();
    check_eq("edge_ren", n_ren, 1);
    check_eq("edge_mv_after_dv", first_mv - first_dv, 1);
    check_eq("edge_ren_idle", fifo_r_en, 0);
    check_eq("edge_pops", n_pop, 1);

    // Stray valid
    inject_stray = 1'b1;
    fifo_dv = 1'b1;
    step();
    inject_stray = 1'b0;
    fifo_dv = 1'b0;
    step();
    check_eq("stray_err", err_stray, 1);
    check_eq("stray_occ", occupancy, 0);
    check_eq("stray_valid", m_valid, 0);
    repeat (3) step();
    check_eq("stray_sticky", err_stray, 1);

    // Reset mid-stream
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'h50 + i);
    for (int i = 0; i < 20; i++) begin
      if (occupancy == 2) break;
      step();
    end
    check_eq("pre_rst_occ", occupancy, 2);
    rst = 1'b1;
    #1;
    check_eq("midrst_ren_gated", fifo_r_en, 0);
    fifo_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    step();
    rst = 1'b0;
    clear_stats();
    check_eq("post_rst_valid", m_valid, 0);
    check_eq("post_rst_data", m_data, 0);
    check_eq("post_rst_occ", occupancy, 0);
    check_eq("post_rst_err", err_stray, 0);
    check_eq("post_rst_ren", fifo_r_en, 0);
    m_ready = 1'b1;
    repeat (6) step();
    check_eq("post_rst_no_emit", n_pop, 0);

    // Random backpressure over 300 words
    for (int i = 0; i < 300; i++) push_word($urandom);
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !m_valid) break;
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    m_ready = 1'b1;
    wait_drain(10);
    check_eq("rand_pops", n_pop, 300);
`ifdef FIFO_RD_STREAM_ADAPTER_XFER_CNT_EN
    check_eq("xfer_cnt_300", xfer_cnt, 300);
    m_ready = 1'b0;
    step();
    force dut.xfer_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.xfer_cnt_q;
    push_word(32'hC0DE);
    m_ready = 1'b1;
    wait_drain(20);
    check_eq("xfer_cnt_wrap", xfer_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
